// File: rtl/muldiv_sequencer.sv
// Multicycle signed multiply (radix-2 Booth) / restoring divide unit producing Hi/Lo.
// Optional MULDIV_UNSIGNED_EN enables multu (op 10) and divu (op 11); otherwise those ops are reserved.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, nextState_s;

  // Shared work registers: accum/shiftReg hold {acc,multiplier} for Booth or {remainder,quotient} for divide
  logic [WIDTH:0]   accum_r;
  logic [WIDTH-1:0] shiftReg_r;
  logic [WIDTH:0]   operand_r;
  logic             qm1_r;
  logic             unsigned_r;
  logic             negQuo_r;
  logic             negRem_r;
  logic [CW-1:0]    count_r;

  logic             busy_r, done_r, divZero_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             isMult_s, isDiv_s, isUns_s, lastStep_s;
  logic [WIDTH:0]   boothSum_s, accNext_s;
  logic [WIDTH-1:0] mplrNext_s, hiMul_s;
  logic [WIDTH:0]   divShift_s, remNext_s;
  logic [WIDTH+1:0] divDiff_s;
  logic             divNeg_s;
  logic [WIDTH-1:0] quoNext_s, hiDiv_s, loDiv_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = {WIDTH{1'b0}} - v;
  endfunction

  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
    absVal = v[WIDTH-1] ? negate(v) : v;
  endfunction

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = divZero_r;
  assign Hi       = hi_r;
  assign Lo       = lo_r;

  // Operation decode; unrecognised ops fall through as reserved
  always_comb begin
    isMult_s = 1'b0;
    isDiv_s  = 1'b0;
    isUns_s  = 1'b0;
    case (op)
      2'b00: isMult_s = 1'b1;
      2'b01: isDiv_s  = 1'b1;
`ifdef MULDIV_UNSIGNED_EN
      2'b10: begin isMult_s = 1'b1; isUns_s = 1'b1; end
      2'b11: begin isDiv_s  = 1'b1; isUns_s = 1'b1; end
`endif
      default: isMult_s = 1'b0;
    endcase
  end

  // One Booth step and one restoring-divide step, evaluated from the work registers
  always_comb begin
    case ({shiftReg_r[0], qm1_r})
      2'b01:   boothSum_s = accum_r + operand_r;
      2'b10:   boothSum_s = accum_r - operand_r;
      default: boothSum_s = accum_r;
    endcase
    accNext_s  = {boothSum_s[WIDTH], boothSum_s[WIDTH:1]};
    mplrNext_s = {boothSum_s[0], shiftReg_r[WIDTH-1:1]};
    // Booth treats the multiplier as signed; an unsigned multiplier with MSB set needs mcand added to Hi
    if (unsigned_r && shiftReg_r[0]) begin
      hiMul_s = accNext_s[WIDTH-1:0] + operand_r[WIDTH-1:0];
    end else begin
      hiMul_s = accNext_s[WIDTH-1:0];
    end

    divShift_s = {accum_r[WIDTH-1:0], shiftReg_r[WIDTH-1]};
    divDiff_s  = {1'b0, divShift_s} - {1'b0, operand_r};
    divNeg_s   = divDiff_s[WIDTH+1];
    remNext_s  = divNeg_s ? divShift_s : divDiff_s[WIDTH:0];
    quoNext_s  = {shiftReg_r[WIDTH-2:0], ~divNeg_s};
    loDiv_s    = negQuo_r ? negate(quoNext_s) : quoNext_s;
    hiDiv_s    = negRem_r ? negate(remNext_s[WIDTH-1:0]) : remNext_s[WIDTH-1:0];
    lastStep_s = (count_r == CNT_ONE);
  end

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (isMult_s) begin
            nextState_s = MULT;
          end else if (isDiv_s && (opB != {WIDTH{1'b0}})) begin
            nextState_s = DIV;
          end else begin
            nextState_s = DONE;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      MULT: begin
        if (lastStep_s) nextState_s = DONE;
        else            nextState_s = MULT;
      end
      DIV: begin
        if (lastStep_s) nextState_s = DONE;
        else            nextState_s = DIV;
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register with registered busy/done flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE);
      done_r  <= (nextState_s == DONE);
    end
  end

  // Operand capture, iteration datapath and Hi/Lo result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      accum_r    <= {(WIDTH+1){1'b0}};
      shiftReg_r <= {WIDTH{1'b0}};
      operand_r  <= {(WIDTH+1){1'b0}};
      qm1_r      <= 1'b0;
      unsigned_r <= 1'b0;
      negQuo_r   <= 1'b0;
      negRem_r   <= 1'b0;
      count_r    <= {CW{1'b0}};
      divZero_r  <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            count_r    <= CNT_INIT;
            divZero_r  <= 1'b0;
            unsigned_r <= isUns_s;
            accum_r    <= {(WIDTH+1){1'b0}};
            qm1_r      <= 1'b0;
            if (isDiv_s) begin
              shiftReg_r <= isUns_s ? opA : absVal(opA);
              operand_r  <= {1'b0, (isUns_s ? opB : absVal(opB))};
              negQuo_r   <= ~isUns_s & (opA[WIDTH-1] ^ opB[WIDTH-1]);
              negRem_r   <= ~isUns_s & opA[WIDTH-1];
              if (opB == {WIDTH{1'b0}}) begin
                hi_r      <= opA;
                lo_r      <= {WIDTH{1'b1}};
                divZero_r <= 1'b1;
              end
            end else begin
              shiftReg_r <= opB;
              operand_r  <= {(isUns_s ? 1'b0 : opA[WIDTH-1]), opA};
              negQuo_r   <= 1'b0;
              negRem_r   <= 1'b0;
            end
          end
        end
        MULT: begin
          count_r    <= count_r - CNT_ONE;
          accum_r    <= accNext_s;
          shiftReg_r <= mplrNext_s;
          qm1_r      <= shiftReg_r[0];
          if (lastStep_s) begin
            hi_r <= hiMul_s;
            lo_r <= mplrNext_s;
          end
        end
        DIV: begin
          count_r    <= count_r - CNT_ONE;
          accum_r    <= remNext_s;
          shiftReg_r <= quoNext_s;
          if (lastStep_s) begin
            hi_r <= hiDiv_s;
            lo_r <= loDiv_s;
          end
        end
        DONE:    count_r <= {CW{1'b0}};
        default: count_r <= {CW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and randomized ops against a plain-arithmetic model.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] opA   = 32'd0;
  logic [31:0] opB   = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;
  logic        expDz = 1'b0;

  always #5 clock = ~clock;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .div_zero(div_zero), .Hi(Hi), .Lo(Lo)
  );

  // Reference: full-width arithmetic on sign/zero-extended 64-bit values
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (o)
      2'b00: begin p = sa * sb; expHi = p[63:32]; expLo = p[31:0]; expDz = 1'b0; end
      2'b01: begin
        if (b == 32'd0) begin expHi = a; expLo = 32'hFFFFFFFF; expDz = 1'b1; end
        else begin q = sa / sb; r = sa % sb; expLo = q[31:0]; expHi = r[31:0]; expDz = 1'b0; end
      end
`ifdef MULDIV_UNSIGNED_EN
      2'b10: begin p = {32'd0, a} * {32'd0, b}; expHi = p[63:32]; expLo = p[31:0]; expDz = 1'b0; end
      2'b11: begin
        if (b == 32'd0) begin expHi = a; expLo = 32'hFFFFFFFF; expDz = 1'b1; end
        else begin expLo = a / b; expHi = a % b; expDz = 1'b0; end
      end
`endif
      default: expDz = 1'b0;
    endcase
  endtask

  function automatic int exp_cycle(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_UNSIGNED_EN
    if (o[0] && b == 32'd0) return 1;
    return 33;
`else
    if (o[1]) return 1;
    if (o[0] && b == 32'd0) return 1;
    return 33;
`endif
  endfunction

  // Issue one op; return the cycle done was seen (-1 if none within budget) and count cycles with busy low
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int doneCyc, output int busyBad);
    @(negedge clock);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); opA = $urandom; opB = $urandom;
    doneCyc = -1; busyBad = 0;
    for (int c = 1; c <= 40 && doneCyc < 0; c++) begin
      if (c > 1) begin @(posedge clock); #1; end
      if (done === 1'b1) doneCyc = c;
      if (busy !== 1'b1) busyBad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; op = 2'b00; opA = 32'd7; opB = 32'd3;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, div_zero, Hi, Lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b Hi=%h Lo=%h, want all 0", busy, done, div_zero, Hi, Lo);
    end
    @(negedge clock); reset = 1'b1; start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
  endtask

  task automatic test_mult;
    int dc, bb;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin a = 32'd7;        b = 32'hFFFFFFFD; end
      else if (i == 1) begin a = 32'h80000000; b = 32'h80000000; end
      else begin
        a = $urandom; b = $urandom;
        if (i % 3 == 0) a = 32'($signed($urandom_range(0, 200)) - 100);
      end
      ref_model(2'b00, a, b);
      run_op(2'b00, a, b, dc, bb);
      checks++;
      if (dc !== 33 || bb !== 0) begin errors++; $display("FAIL mult_timing %0d: done cycle %0d busy-low %0d, want 33 and 0", i, dc, bb); end
      checks++;
      if (Hi !== expHi || Lo !== expLo || div_zero !== 1'b0) begin
        errors++; $display("FAIL mult_result %h*%h: got %h_%h dz=%b, want %h_%h dz=0", a, b, Hi, Lo, div_zero, expHi, expLo);
      end
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mult_idle: busy=%b done=%b want 0 0", busy, done); end
    end
  endtask

  task automatic test_div;
    int dc, bb;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin a = 32'hFFFFFFF9; b = 32'd2; end
      else if (i == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else begin
        a = $urandom; b = (i % 2 == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
        if (b == 32'd0) b = 32'd3;
      end
      ref_model(2'b01, a, b);
      run_op(2'b01, a, b, dc, bb);
      checks++;
      if (dc !== 33 || bb !== 0) begin errors++; $display("FAIL div_timing %0d: done cycle %0d busy-low %0d, want 33 and 0", i, dc, bb); end
      checks++;
      if (Hi !== expHi || Lo !== expLo || div_zero !== 1'b0) begin
        errors++; $display("FAIL div_result %h/%h: got Hi=%h Lo=%h dz=%b, want Hi=%h Lo=%h dz=0", a, b, Hi, Lo, div_zero, expHi, expLo);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_div_zero;
    int dc, bb;
    run_op(2'b01, 32'd5, 32'd0, dc, bb);
    checks++;
    if (dc !== 1 || Hi !== 32'd5 || Lo !== 32'hFFFFFFFF || div_zero !== 1'b1) begin
      errors++; $display("FAIL div_zero: cycle %0d Hi=%h Lo=%h dz=%b, want 1 5 ffffffff 1", dc, Hi, Lo, div_zero);
    end
    @(posedge clock); #1;
    checks++;
    if (div_zero !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL div_zero_hold: dz=%b busy=%b want 1 0", div_zero, busy); end
    ref_model(2'b00, 32'd20, 32'd3);
    run_op(2'b00, 32'd20, 32'd3, dc, bb);
    checks++;
    if (div_zero !== 1'b0 || Lo !== expLo || dc !== 33) begin
      errors++; $display("FAIL div_zero_clear: dz=%b Lo=%h cycle %0d, want 0 %h 33", div_zero, Lo, dc, expLo);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_ignore_start;
    int dc;
    ref_model(2'b00, 32'd3, 32'd4);
    @(negedge clock); start = 1'b1; op = 2'b00; opA = 32'd3; opB = 32'd4;
    @(posedge clock); #1; start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (c > 1) begin @(posedge clock); #1; end
      if (c == 10) begin start = 1'b1; op = 2'b01; opA = 32'd9; opB = 32'd3; end
      else start = 1'b0;
      if (done === 1'b1) dc = c;
    end
    checks++;
    if (dc !== 33 || Hi !== 32'd0 || Lo !== 32'd12) begin
      errors++; $display("FAIL ignore_start: cycle %0d Hi=%h Lo=%h, want 33 0 c", dc, Hi, Lo);
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort;
    int doneSeen;
    @(negedge clock); start = 1'b1; op = 2'b00; opA = 32'd3; opB = 32'd4;
    @(posedge clock); #1; start = 1'b0;
    doneSeen = 0;
    for (int c = 2; c <= 15; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) doneSeen++;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: busy=%b done=%b Hi=%h Lo=%h, want 0 0 0 0", busy, done, Hi, Lo);
    end
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin errors++; $display("FAIL reset_abort_done: %0d done pulses, want 0", doneSeen); end
    expHi = 32'd0; expLo = 32'd0;
  endtask

`ifdef MULDIV_UNSIGNED_EN
  task automatic test_unsigned;
    int dc, bb;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin a = 32'hFFFFFFFF; b = 32'd2; end
      else begin a = $urandom; b = $urandom; if (b == 32'd0) b = 32'd1; end
      ref_model(2'b10, a, b);
      run_op(2'b10, a, b, dc, bb);
      checks++;
      if (dc !== 33 || Hi !== expHi || Lo !== expLo) begin
        errors++; $display("FAIL multu %h*%h: cycle %0d got %h_%h, want 33 %h_%h", a, b, dc, Hi, Lo, expHi, expLo);
      end
      @(posedge clock); #1;
      ref_model(2'b11, a, b);
      run_op(2'b11, a, b, dc, bb);
      checks++;
      if (dc !== 33 || Hi !== expHi || Lo !== expLo || div_zero !== 1'b0) begin
        errors++; $display("FAIL divu %h/%h: cycle %0d Hi=%h Lo=%h, want 33 %h %h", a, b, dc, Hi, Lo, expHi, expLo);
      end
      @(posedge clock); #1;
    end
  endtask
`else
  task automatic test_reserved;
    int dc, bb;
    logic [31:0] prevHi, prevLo;
    for (int i = 0; i < 2; i++) begin
      prevHi = Hi;
      prevLo = Lo;
      run_op(2'b10 | 2'(i), $urandom, 32'd0, dc, bb);
      checks++;
      if (dc !== exp_cycle(2'b10 | 2'(i), 32'd0) || Hi !== expHi || Lo !== expLo || div_zero !== 1'b0 || bb !== 0) begin
        errors++; $display("FAIL reserved_op %0d: cycle %0d Hi=%h Lo=%h dz=%b (was %h %h), want 1 %h %h 0",
                           i, dc, Hi, Lo, div_zero, prevHi, prevLo, expHi, expLo);
      end
      @(posedge clock); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
`ifdef MULDIV_UNSIGNED_EN
    test_unsigned();
`else
    ref_model(2'b00, 32'd11, 32'hFFFFFFF0);
    begin
      int dc, bb;
      run_op(2'b00, 32'd11, 32'hFFFFFFF0, dc, bb);
      @(posedge clock); #1;
    end
    test_reserved();
`endif
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
